// File: rtl/barrett_2_reg_pkg.sv
// Width helpers shared by the Barrett digit-serial multiplier.
// Build option: BARRETT_QDEBUG_EN enables the registered q_i debug tap.
package barrett_pkg;

  localparam int NCORR = 3;

  function automatic int f_k(input int n, input int m);
    return n / m;
  endfunction

  function automatic int f_tw(input int n, input int m);
    return n + m + 2;
  endfunction

  function automatic int f_qw(input int m);
    return m + 2;
  endfunction

  function automatic int f_muw(input int m);
    return m + 7;
  endfunction

endpackage

// File: rtl/barrett_2_reg_if.sv
// Host-side operand/result bundle for barrett_2_reg.
// Build option: BARRETT_QDEBUG_EN (affects only the q_i driver).
interface barrett_2_reg_if #(
  parameter int n = 8,
  parameter int m = 4
);
  import barrett_pkg::*;

  logic [n-1:0]         X;
  logic [m-1:0]         Y_i;
  logic [n-1:0]         M;
  logic [f_muw(m)-1:0]  mu;
  logic [2*n-1:0]       Z_OUT;
  logic [2:0]           q_i;

  modport master (
    output X, Y_i, M, mu,
    input  Z_OUT, q_i
  );

  modport slave (
    input  X, Y_i, M, mu,
    output Z_OUT, q_i
  );

endinterface

// File: rtl/barrett_2_reg_qest.sv
// Barrett quotient estimate: qh = ((T >> (n-2)) * mu) >> (m+5).
// Build option: BARRETT_QDEBUG_EN has no effect here.
module barrett_qest
  import barrett_pkg::*;
#(
  parameter int n = 8,
  parameter int m = 4
) (
  input  logic [f_tw(n,m)-1:0] i_t,
  input  logic [f_muw(m)-1:0]  i_mu,
  output logic [f_qw(m)-1:0]   o_qh
);

  localparam int TW  = f_tw(n, m);
  localparam int HW  = TW - (n - 2);
  localparam int MUW = f_muw(m);
  localparam int QW  = f_qw(m);
  localparam int PW  = HW + MUW;

  logic [HW-1:0] w_th;
  logic [PW-1:0] w_prod;

  assign w_th   = HW'(i_t >> (n - 2));
  assign w_prod = PW'(w_th) * PW'(i_mu);
  assign o_qh   = QW'(w_prod >> (m + 5));

endmodule

// File: rtl/barrett_2_reg.sv
// Digit-serial Barrett modular multiplier, one Y digit per clock, MSD first.
// Build option: BARRETT_QDEBUG_EN adds the registered q_i debug tap.
module barrett_2_reg
  import barrett_pkg::*;
#(
  parameter int n = 8,
  parameter int m = 4
) (
  input  logic CLK,
  input  logic RST,
  barrett_2_reg_if.slave bus
);

  localparam int TW = f_tw(n, m);
  localparam int QW = f_qw(m);

  logic [TW-1:0] r_z;
  logic [TW-1:0] w_t;
  logic [TW-1:0] w_qm;
  logic [TW-1:0] w_mx;
  logic [TW-1:0] w_r;
  logic [QW-1:0] w_qh;

  // r_z stays below M, so the shift never loses set bits
  assign w_t  = (r_z << m) + TW'(bus.X) * TW'(bus.Y_i);
  assign w_mx = TW'(bus.M);
  assign w_qm = TW'(w_qh) * w_mx;

  barrett_qest #(
    .n(n),
    .m(m)
  ) u_qest (
    .i_t  (w_t),
    .i_mu (bus.mu),
    .o_qh (w_qh)
  );

  always_comb begin
    w_r = w_t - w_qm;
    for (int i = 0; i < NCORR; i++) begin
      if (w_r >= w_mx) begin
        w_r = w_r - w_mx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_z <= '0;
    end else begin
      r_z <= w_r;
    end
  end

  assign bus.Z_OUT = (2*n)'(r_z);

`ifdef BARRETT_QDEBUG_EN
  logic [2:0] r_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= 3'b000;
    end else begin
      r_q <= 3'(w_qh);
    end
  end

  assign bus.q_i = r_q;
`else
  assign bus.q_i = 3'b000;
`endif

endmodule

// File: tb/tb_barrett_2_reg.sv
// Scoreboard bench for barrett_2_reg (n=8, m=4), directed vectors.
// Works with or without BARRETT_QDEBUG_EN defined.
module tb_barrett_2_reg;

`ifdef BARRETT_QDEBUG_EN
  localparam bit QDBG = 1'b1;
`else
  localparam bit QDBG = 1'b0;
`endif

  typedef struct {
    logic [15:0] z;
    logic [2:0]  q;
    string       nm;
  } exp_t;

  logic CLK;
  logic RST;
  bit   step_pend;
  int   n_vec;
  int   n_bad;
  exp_t sbq[$];

  barrett_2_reg_if #(.n(8), .m(4)) bus ();

  barrett_2_reg #(.n(8), .m(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (step_pend) begin
      #1;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: DUT stepped with no expected entry");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        n_vec++;
        if (bus.Z_OUT !== e.z) begin
          n_bad++;
          $display("FAIL %s Z_OUT: got %0d want %0d", e.nm, bus.Z_OUT, e.z);
        end
        n_vec++;
        if (bus.q_i !== e.q) begin
          n_bad++;
          $display("FAIL %s q_i: got %0d want %0d", e.nm, bus.q_i, e.q);
        end
      end
    end
  end

  task automatic setop(input logic [7:0] x, input logic [7:0] mm,
                       input logic [10:0] u);
    bus.X  = x;
    bus.M  = mm;
    bus.mu = u;
  endtask

  task automatic apply(input logic rst, input logic [3:0] y,
                       input logic [15:0] ez, input logic [2:0] eq,
                       input string nm);
    exp_t e;
    RST     = rst;
    bus.Y_i = y;
    e.z     = ez;
    e.q     = QDBG ? eq : 3'b000;
    e.nm    = nm;
    sbq.push_back(e);
    step_pend = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    step_pend = 1'b0;
    RST       = 1'b1;
    setop(8'd0, 8'd251, 11'd130);
    bus.Y_i   = 4'd0;
    @(negedge CLK);

    apply(1'b1, 4'd0, 16'd0, 3'd0, "reset");

    setop(8'd200, 8'd251, 11'd130);
    apply(1'b1, 4'd0, 16'd0, 3'd0, "t1_rst");
    apply(1'b0, 4'd9, 16'd43, 3'd7, "t1_d1");
    apply(1'b0, 4'd6, 16'd131, 3'd7, "t1_d2");

    setop(8'd100, 8'd193, 11'd169);
    apply(1'b1, 4'd0, 16'd0, 3'd0, "t2_rst");
    apply(1'b0, 4'd0, 16'd0, 3'd0, "t2_d1");
    apply(1'b0, 4'd3, 16'd107, 3'd1, "t2_d2");

    setop(8'd255, 8'd255, 11'd128);
    apply(1'b1, 4'd0, 16'd0, 3'd0, "corr_rst");
    apply(1'b0, 4'd15, 16'd0, 3'd6, "corr_d1");
    apply(1'b0, 4'd15, 16'd0, 3'd6, "corr_d2");

    setop(8'd200, 8'd251, 11'd130);
    apply(1'b1, 4'd0, 16'd0, 3'd0, "abort_rst");
    apply(1'b0, 4'd9, 16'd43, 3'd7, "abort_d1");
    apply(1'b1, 4'd6, 16'd0, 3'd0, "abort_mid");
    apply(1'b0, 4'd9, 16'd43, 3'd7, "restart_d1");
    apply(1'b0, 4'd6, 16'd131, 3'd7, "restart_d2");

    setop(8'd0, 8'd251, 11'd130);
    apply(1'b1, 4'd0, 16'd0, 3'd0, "x0_rst");
    apply(1'b0, 4'd9, 16'd0, 3'd0, "x0_d1");
    apply(1'b0, 4'd6, 16'd0, 3'd0, "x0_d2");

    setop(8'd200, 8'd251, 11'd130);
    apply(1'b1, 4'd0, 16'd0, 3'd0, "y0_rst");
    apply(1'b0, 4'd0, 16'd0, 3'd0, "y0_d1");
    apply(1'b0, 4'd0, 16'd0, 3'd0, "y0_d2");

    apply(1'b1, 4'd0, 16'd0, 3'd0, "ylo0_rst");
    apply(1'b0, 4'd9, 16'd43, 3'd7, "ylo0_d1");
    apply(1'b0, 4'd0, 16'd186, 3'd2, "ylo0_d2");

    setop(8'd255, 8'd193, 11'd169);
    apply(1'b1, 4'd0, 16'd0, 3'd0, "xgem_rst");
    apply(1'b0, 4'd15, 16'd158, 3'd3, "xgem_d1");
    apply(1'b0, 4'd15, 16'd177, 3'd0, "xgem_d2");

    RST       = 1'b1;
    step_pend = 1'b0;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
      @(negedge CLK);
    end
    if (sbq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
